// File: rtl/taylor_cos_seq.sv
// taylor_cos_seq: Horner-rule cos(x) over a shared request/ack float ALU, with an alu_req timeout abort to ERR.
// Define TAYLOR_SIN_EN to add sin_sel, which selects the sin(x) series instead.
module taylor_cos_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
`ifdef TAYLOR_SIN_EN
  input  logic        sin_sel,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_req,
  input  logic [63:0] alu_res,
  input  logic        alu_ack
);
  localparam logic [4:0]  OP_MUL = 5'b00111;
  localparam logic [4:0]  OP_ADD = 5'b00101;
  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam int          TW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0] C0 = 32'h3F800000, C2 = 32'hBF000000, C4 = 32'h3D2AAAAB;
  localparam logic [31:0] C6 = 32'hBAB60B61, C8 = 32'h37D00D01, C10 = 32'hB493F27E;
  localparam logic [31:0] S1 = 32'h3F800000, S3 = 32'hBE2AAAAB, S5 = 32'h3C088889;
  localparam logic [31:0] S7 = 32'hB9500D01, S9 = 32'h3638EF1D;

  typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [31:0]   x_q, x2_q, acc_q, coef;
  logic [3:0]    idx_q;
  logic [TW-1:0] tcnt_q;
  logic          sin_q, start_sin, last_op, timeout;
  logic          unused_res_hi;

`ifdef TAYLOR_SIN_EN
  assign start_sin = sin_sel;
`else
  assign start_sin = 1'b0;
`endif

  assign unused_res_hi = ^alu_res[63:32];
  assign last_op = (idx_q == (sin_q ? 4'd9 : 4'd10));
  assign timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign busy    = (state == REQ) || (state == GAP);
  assign done    = (state == DONE) || (state == ERR);

  // ADD steps sit at even op indices 2..10, walking coefficients from high order down
  always_comb begin
    coef = C0;
    case (idx_q)
      4'd2:    coef = sin_q ? S7 : C8;
      4'd4:    coef = sin_q ? S5 : C6;
      4'd6:    coef = sin_q ? S3 : C4;
      4'd8:    coef = sin_q ? S1 : C2;
      default: coef = C0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (alu_ack)      state_nxt = last_op ? DONE : GAP;
        else if (timeout) state_nxt = ERR;
      end
      GAP:       state_nxt = REQ;
      DONE, ERR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Operands are decoded from registers that only move on ack, so they hold while alu_req is high
  always_comb begin
    alu_req = 1'b0;
    alu_op  = 5'b00000;
    alu_a   = 32'h0;
    alu_b   = 32'h0;
    if (state == REQ) begin
      alu_req = 1'b1;
      alu_a   = acc_q;
      if (idx_q == 4'd0) begin
        alu_op = OP_MUL;
        alu_a  = x_q;
        alu_b  = x_q;
      end else if (idx_q[0]) begin
        alu_op = OP_MUL;
        alu_b  = (sin_q && last_op) ? x_q : x2_q;
      end else begin
        alu_op = OP_ADD;
        alu_b  = coef;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= 32'h0;
      x2_q   <= 32'h0;
      acc_q  <= 32'h0;
      idx_q  <= 4'd0;
      tcnt_q <= '0;
      sin_q  <= 1'b0;
      result <= 32'h0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q    <= x_in;
          sin_q  <= start_sin;
          acc_q  <= start_sin ? S9 : C10;
          idx_q  <= 4'd0;
          tcnt_q <= '0;
          err    <= 1'b0;
        end
        REQ: begin
          if (alu_ack) begin
            tcnt_q <= '0;
            idx_q  <= idx_q + 4'd1;
            if (idx_q == 4'd0) x2_q <= alu_res[31:0];
            else               acc_q <= alu_res[31:0];
            if (last_op) result <= alu_res[31:0];
          end else if (timeout) begin
            err    <= 1'b1;
            result <= QNAN;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/taylor_cos_seq.md
TAYLOR_COS_SEQ -- requirements
Module: taylor_cos_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum number of cycles alu_req may stay high without alu_ack before the block aborts.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to evaluate the series for x_in.
REQ-005 x_in  input  32  IEEE-754 single-precision angle in radians, sampled on the edge that accepts start.
REQ-006 busy  output  1  high from start acceptance until done.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 result  output  32  IEEE-754 single-precision result, held until the next start is accepted.
REQ-009 err  output  1  high when the last run aborted on timeout; cleared when the next start is accepted.
REQ-010 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-011 alu_op  output  5  operation code: MUL 5'b00111, ADD 5'b00101.
REQ-012 alu_req  output  1  operation request; alu_a, alu_b and alu_op are held stable while it is high.
REQ-013 alu_res  input  64  ALU result; only bits [31:0] are used.
REQ-014 alu_ack  input  1  ALU completion; alu_res is valid in the same cycle.

Function
REQ-015 The block SHALL evaluate cos(x) = 1 + x2*(c2 + x2*(c4 + x2*(c6 + x2*(c8 + x2*c10)))) by Horner's rule, issuing 11 ALU operations.
- Operation 0: x2 = x*x.
- Initial value: acc = c10.
- For k = 8, 6, 4, 2, 0: acc = acc*x2, then acc = acc + ck.
REQ-016 The coefficients SHALL be fixed constants: c0 0x3F800000, c2 0xBF000000, c4 0x3D2AAAAB, c6 0xBAB60B61, c8 0x37D00D01, c10 0xB493F27E.
REQ-017 The FSM states SHALL be IDLE, REQ, GAP, DONE and ERR.
- IDLE to REQ on start.
- REQ to GAP on alu_ack when operations remain.
- REQ to DONE on alu_ack after the last operation.
- REQ to ERR on timeout.
- GAP to REQ after 1 cycle.
- DONE to IDLE and ERR to IDLE after 1 cycle.
REQ-018 The handshake SHALL follow these rules:
- alu_req is high exactly in the REQ state.
- alu_res[31:0] is captured on the edge where alu_ack=1 is sampled.
- alu_req is low for at least 1 cycle between operations.
- alu_ack is ignored while alu_req is low.
REQ-019 start SHALL be ignored while the block is in REQ, GAP, DONE or ERR.
REQ-020 On timeout, when alu_req has been high for TIMEOUT_CYCLES cycles without alu_ack, the block SHALL enter ERR: err=1, result=0x7FC00000, done pulses for 1 cycle, busy falls.
REQ-021 Latency SHALL be as follows when the responder acks in the 2nd cycle of each request:
- Operation k occupies cycles 3k+1 to 3k+3 after the edge that accepted start.
- done is high in cycle 33, and result is valid from that cycle.
REQ-022 done and busy SHALL never be high in the same cycle.

Reset
REQ-023 Asserting rst_n low SHALL immediately force the following, including mid-operation:
- State is IDLE.
- busy, done, err, alu_req are 0.
- result, alu_a, alu_b are 0.
- alu_op is 5'b00000.
REQ-024 After rst_n is released, the block SHALL accept start from the first rising edge.

Configuration
REQ-025 With TAYLOR_SIN_EN defined, the block SHALL add input sin_sel (1 bit, sampled with start).
- When sin_sel=1, the block computes sin(x) = x*(s1 + x2*(s3 + x2*(s5 + x2*(s7 + x2*s9)))).
- Coefficients: s1 0x3F800000, s3 0xBE2AAAAB, s5 0x3C088889, s7 0xB9500D01, s9 0x3638EF1D.
- The sin path uses 10 operations: square, 4 MUL/ADD pairs, final MUL by x.
- done is high in cycle 30.
REQ-026 Without TAYLOR_SIN_EN, the sin_sel port SHALL not exist and the block computes cosine only.

Verification
REQ-027 Exact float ALU model acking in the 2nd request cycle; start with x_in=0x00000000 -> done in cycle 33, result=0x3F800000, err=0.
REQ-028 x_in=0x3EE85696 (0.45378 rad) -> |result - 0.898794| < 1e-6, and exactly 11 alu_req rising edges with op sequence MUL followed by 5 pairs of MUL, ADD.
REQ-029 Responder with random 0-10 cycle ack delay; start pulsed every cycle while busy -> extra starts ignored, alu_a, alu_b and alu_op stable while alu_req is high, same result as REQ-028.
REQ-030 Responder never acks, TIMEOUT_CYCLES=64 -> ERR after 64 request cycles, done pulse, err=1, result=0x7FC00000; next start clears err.
REQ-031 rst_n pulsed low during operation 5 -> alu_req and busy drop asynchronously; a fresh start then completes with the correct result.
REQ-032 TAYLOR_SIN_EN defined, sin_sel=1, x_in=0x3EE85696 -> done in cycle 30, |result - 0.438371| < 1e-6.
